id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that feeds the 3-bit-op, 32-bit ALU.
- Latches decoded fields each cycle and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results.
- Detects load-use hazards and inserts bubbles for them.
- Presents alu_op, operand_a and operand_b to the ALU combinationally from the registered state.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-address width
OP_W, 3, ALU op width (ADD=0 SUB=1 AND=2 OR=3 XOR=4 SRA=5 SRL=6 SLT=7)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  decode slot holds a real instruction
id_rs1_i / id_rs2_i  in  REG_AW  source register addresses
id_use_rs1_i / id_use_rs2_i  in  1  instruction reads rs1 / rs2
id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data
id_imm_i  in  XLEN  immediate
id_use_imm_i  in  1  operand_b = imm
id_alu_op_i  in  OP_W  ALU operation
id_rd_i  in  REG_AW  destination register
id_reg_write_i  in  1  writes rd
id_is_load_i  in  1  load instruction
mem_stall_i  in  1  downstream freeze
flush_i  in  1  kill the instruction entering ID/EX
exm_rd_i, exm_reg_write_i, exm_is_load_i, exm_result_i  in  REG_AW/1/1/XLEN  EX/MEM forwarding source
wb_rd_i, wb_reg_write_i, wb_result_i  in  REG_AW/1/XLEN  MEM/WB forwarding source
stall_o  out  1  load-use hazard; upstream holds PC and IF/ID
ex_valid_o  out  1  EX slot valid
alu_op_o  out  OP_W  to ALU
operand_a_o / operand_b_o  out  XLEN  to ALU
store_data_o  out  XLEN  forwarded rs2
ex_rd_o, ex_reg_write_o, ex_is_load_o  out  REG_AW/1/1  to EX/MEM

Behaviour:
- Reset (rst_n=0, asynchronous): every ID/EX register is cleared to 0, so ex_valid_o=0, alu_op_o=ADD, operands=0, ex_rd_o=0 and ex_reg_write_o=0. A reset in mid-operation discards the in-flight instruction.
- Latency: the ID/EX register has 1 cycle of latency. Forwarding muxes are combinational after the register.
- Register update priority at each posedge: mem_stall_i (hold all) > flush_i (valid←0 and reg_write←0; other fields don't-care) > hazard (bubble, same as flush) > load the id_* fields.
- When mem_stall_i is asserted, flush_i is ignored. The upstream stage holds flush_i asserted until the freeze releases.
- hazard = ex_valid & ex_is_load & ex_rd≠0 & id_valid_i & ((id_use_rs1_i & rd==rs1) | (id_use_rs2_i & rd==rs2)).
- stall_o = hazard & ~flush_i, combinational. A bubble lasts exactly 1 cycle, then the load leaves EX.
- Forwarding per source operand (registered rs1 and rs2):
  - A source address of 0 is never forwarded.
  - EX/MEM is selected if exm_reg_write_i, exm_rd_i matches and ~exm_is_load_i.
  - Otherwise MEM/WB is selected if wb_reg_write_i and wb_rd_i matches.
  - Otherwise the registered register-file data is used.
  - If both sources match, EX/MEM wins.
- operand_a_o = fwd_rs1.
- operand_b_o = use_imm ? imm : fwd_rs2.
- store_data_o = fwd_rs2 regardless of use_imm.
- While ex_valid_o=0, outputs carry stale data. Downstream qualifies them with ex_valid_o.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_o[31:0] and perf_freeze_o[31:0].
  - perf_bubble_o counts cycles where hazard&~mem_stall_i.
  - perf_freeze_o counts mem_stall_i cycles.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package cpu_pkg holds:
  - the ALU op localparams ADD..SLT;
  - XLEN and REG_AW;
  - the forward-select encoding FWD_RF=0, FWD_EXM=1, FWD_WB=2.
- One sub-module, fwd_unit: purely combinational hazard detection and forward-select generation. It is instantiated once, and the operand muxes use its selects.

Test Plan:
- ADD x3=x1+x2 (rf x1=5, x2=7) with no hazards → next cycle ex_valid_o=1, alu_op_o=0, operand_a_o=5, operand_b_o=7.
- EX/MEM write x1=0x10 while EX reads x1, and WB also writes x1=0x20 → operand_a_o=0x10 (EX/MEM priority).
- Load x4 in EX, decode reads x4 → stall_o=1 for 1 cycle and a bubble (ex_valid_o=0). Next cycle the consumer gets x4 via the WB path.
- Writes to x0 with value 0xDEAD on both forwarding paths, EX reads x0 (rf=0) → operand_a_o=0.
- Apply mem_stall_i for 3 cycles with flush_i high → ID/EX held unchanged. After release, flush makes ex_valid_o=0.
- Assert rst_n low mid-stream, asynchronously between edges → all outputs go to 0 immediately. With ID_EX_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes, forward-select encoding
// and the forwarding select/mux helpers used by the ID/EX stage.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [OP_W-1:0] ALU_SRA = 3'd5;
  localparam logic [OP_W-1:0] ALU_SRL = 3'd6;
  localparam logic [OP_W-1:0] ALU_SLT = 3'd7;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // x0 is hardwired, so it is never forwarded; a load in EX/MEM has no data yet
  function automatic fwd_sel_e fwd_select(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] exm_rd,
                                          input logic              exm_rw,
                                          input logic              exm_ld,
                                          input logic [REG_AW-1:0] wb_rd,
                                          input logic              wb_rw);
    fwd_sel_e sel;
    if (src == {REG_AW{1'b0}}) begin
      sel = FWD_RF;
    end else if (exm_rw && !exm_ld && (exm_rd == src)) begin
      sel = FWD_EXM;
    end else if (wb_rw && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input fwd_sel_e        sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] exm,
                                              input logic [XLEN-1:0] wb);
    logic [XLEN-1:0] val;
    case (sel)
      FWD_RF:  val = rf;
      FWD_EXM: val = exm;
      FWD_WB:  val = wb;
      default: val = rf;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode inputs, forwarding sources and EX-slot outputs of the ID/EX stage.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_use_rs1_i;
  logic              id_use_rs2_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic              id_use_imm_i;
  logic [OP_W-1:0]   id_alu_op_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_reg_write_i;
  logic              id_is_load_i;
  logic              mem_stall_i;
  logic              flush_i;
  logic [REG_AW-1:0] exm_rd_i;
  logic              exm_reg_write_i;
  logic              exm_is_load_i;
  logic [XLEN-1:0]   exm_result_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic              wb_reg_write_i;
  logic [XLEN-1:0]   wb_result_i;

  logic              stall_o;
  logic              ex_valid_o;
  logic [OP_W-1:0]   alu_op_o;
  logic [XLEN-1:0]   operand_a_o;
  logic [XLEN-1:0]   operand_b_o;
  logic [XLEN-1:0]   store_data_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              ex_reg_write_o;
  logic              ex_is_load_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_use_imm_i, id_alu_op_i,
           id_rd_i, id_reg_write_i, id_is_load_i, mem_stall_i, flush_i,
           exm_rd_i, exm_reg_write_i, exm_is_load_i, exm_result_i,
           wb_rd_i, wb_reg_write_i, wb_result_i,
    input  stall_o, ex_valid_o, alu_op_o, operand_a_o, operand_b_o,
           store_data_o, ex_rd_o, ex_reg_write_o, ex_is_load_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rs1_data_i, id_rs2_data_i, id_imm_i, id_use_imm_i, id_alu_op_i,
           id_rd_i, id_reg_write_i, id_is_load_i, mem_stall_i, flush_i,
           exm_rd_i, exm_reg_write_i, exm_is_load_i, exm_result_i,
           wb_rd_i, wb_reg_write_i, wb_result_i,
    output stall_o, ex_valid_o, alu_op_o, operand_a_o, operand_b_o,
           store_data_o, ex_rd_o, ex_reg_write_o, ex_is_load_o
  );
endinterface

// File: rtl/fwd_unit.sv
// Combinational load-use hazard detection and per-operand forward-select generation
// for the instruction held in the ID/EX register.
module fwd_unit
  import cpu_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic              exm_is_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic              hazard,
  output fwd_sel_e          sel_a,
  output fwd_sel_e          sel_b
);

  // hazard when the load in EX writes a register the decode slot is about to read
  always_comb begin
    hazard = ex_valid && ex_is_load && (ex_rd != {REG_AW{1'b0}}) && id_valid &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    sel_a  = fwd_select(ex_rs1, exm_rd, exm_reg_write, exm_is_load, wb_rd, wb_reg_write);
    sel_b  = fwd_select(ex_rs2, exm_rd, exm_reg_write, exm_is_load, wb_rd, wb_reg_write);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional ID_EX_PERF_CNT_EN adds saturating bubble/freeze cycle counters.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]  perf_bubble_o,
  output logic [31:0]  perf_freeze_o
`endif
);

  logic              valid_r;
  logic [REG_AW-1:0] rs1_r;
  logic [REG_AW-1:0] rs2_r;
  logic [XLEN-1:0]   rs1_data_r;
  logic [XLEN-1:0]   rs2_data_r;
  logic [XLEN-1:0]   imm_r;
  logic              use_imm_r;
  logic [OP_W-1:0]   alu_op_r;
  logic [REG_AW-1:0] rd_r;
  logic              reg_write_r;
  logic              is_load_r;

  logic              hazard_s;
  fwd_sel_e          sel_a_s;
  fwd_sel_e          sel_b_s;
  logic [XLEN-1:0]   fwd_rs1_s;
  logic [XLEN-1:0]   fwd_rs2_s;

  fwd_unit u_fwd (
    .ex_valid      (valid_r),
    .ex_is_load    (is_load_r),
    .ex_rd         (rd_r),
    .ex_rs1        (rs1_r),
    .ex_rs2        (rs2_r),
    .id_valid      (bus.id_valid_i),
    .id_use_rs1    (bus.id_use_rs1_i),
    .id_use_rs2    (bus.id_use_rs2_i),
    .id_rs1        (bus.id_rs1_i),
    .id_rs2        (bus.id_rs2_i),
    .exm_rd        (bus.exm_rd_i),
    .exm_reg_write (bus.exm_reg_write_i),
    .exm_is_load   (bus.exm_is_load_i),
    .wb_rd         (bus.wb_rd_i),
    .wb_reg_write  (bus.wb_reg_write_i),
    .hazard        (hazard_s),
    .sel_a         (sel_a_s),
    .sel_b         (sel_b_s)
  );

  // ID/EX register: freeze holds everything, flush or load-use inserts a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      rs1_r       <= {REG_AW{1'b0}};
      rs2_r       <= {REG_AW{1'b0}};
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      use_imm_r   <= 1'b0;
      alu_op_r    <= ALU_ADD;
      rd_r        <= {REG_AW{1'b0}};
      reg_write_r <= 1'b0;
      is_load_r   <= 1'b0;
    end else if (!bus.mem_stall_i) begin
      if (bus.flush_i || hazard_s) begin
        valid_r     <= 1'b0;
        reg_write_r <= 1'b0;
        is_load_r   <= 1'b0;
      end else begin
        valid_r     <= bus.id_valid_i;
        rs1_r       <= bus.id_rs1_i;
        rs2_r       <= bus.id_rs2_i;
        rs1_data_r  <= bus.id_rs1_data_i;
        rs2_data_r  <= bus.id_rs2_data_i;
        imm_r       <= bus.id_imm_i;
        use_imm_r   <= bus.id_use_imm_i;
        alu_op_r    <= bus.id_alu_op_i;
        rd_r        <= bus.id_rd_i;
        reg_write_r <= bus.id_reg_write_i;
        is_load_r   <= bus.id_is_load_i;
      end
    end
  end

  // operand muxes after the register, steered by the forwarding unit
  always_comb begin
    fwd_rs1_s = fwd_mux(sel_a_s, rs1_data_r, bus.exm_result_i, bus.wb_result_i);
    fwd_rs2_s = fwd_mux(sel_b_s, rs2_data_r, bus.exm_result_i, bus.wb_result_i);
  end

  assign bus.stall_o        = hazard_s & ~bus.flush_i;
  assign bus.ex_valid_o     = valid_r;
  assign bus.alu_op_o       = alu_op_r;
  assign bus.operand_a_o    = fwd_rs1_s;
  assign bus.operand_b_o    = use_imm_r ? imm_r : fwd_rs2_s;
  assign bus.store_data_o   = fwd_rs2_s;
  assign bus.ex_rd_o        = rd_r;
  assign bus.ex_reg_write_o = reg_write_r;
  assign bus.ex_is_load_o   = is_load_r;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubble_r;
  logic [31:0] perf_freeze_r;

  // saturating counters of load-use bubbles and downstream freeze cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_r <= 32'd0;
      perf_freeze_r <= 32'd0;
    end else begin
      if (hazard_s && !bus.mem_stall_i && (perf_bubble_r != 32'hFFFF_FFFF)) begin
        perf_bubble_r <= perf_bubble_r + 32'd1;
      end
      if (bus.mem_stall_i && (perf_freeze_r != 32'hFFFF_FFFF)) begin
        perf_freeze_r <= perf_freeze_r + 32'd1;
      end
    end
  end

  assign perf_bubble_o = perf_bubble_r;
  assign perf_freeze_o = perf_freeze_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector scoreboard bench for id_ex_stage: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct {
    int          cyc;
    string       tag;
    logic        stall;
    logic        valid;
    logic        full;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        pchk;
    logic [31:0] pb;
    logic [31:0] pf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  id_ex_stage_if bus();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubble;
  logic [31:0] perf_freeze;
`endif

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .perf_bubble_o (perf_bubble),
    .perf_freeze_o (perf_freeze)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare the scoreboard head against the outputs of its cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", sb_q[0].tag, sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end else if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      exp_t e;
      logic ok;
      e  = sb_q.pop_front();
      ok = (bus.stall_o === e.stall) && (bus.ex_valid_o === e.valid);
      if (e.full) begin
        ok = ok && (bus.alu_op_o === e.op) && (bus.operand_a_o === e.a) &&
             (bus.operand_b_o === e.b) && (bus.store_data_o === e.st) &&
             (bus.ex_rd_o === e.rd) && (bus.ex_reg_write_o === e.rw) &&
             (bus.ex_is_load_o === e.ld);
      end
`ifdef ID_EX_PERF_CNT_EN
      if (e.pchk) begin
        ok = ok && (perf_bubble === e.pb) && (perf_freeze === e.pf);
      end
`endif
      n_checks = n_checks + 1;
      if (!ok) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got stall=%0b valid=%0b op=%0d a=%h b=%h st=%h rd=%0d rw=%0b ld=%0b; expected stall=%0b valid=%0b op=%0d a=%h b=%h st=%h rd=%0d rw=%0b ld=%0b (data checked=%0b)",
                 e.tag, bus.stall_o, bus.ex_valid_o, bus.alu_op_o, bus.operand_a_o, bus.operand_b_o,
                 bus.store_data_o, bus.ex_rd_o, bus.ex_reg_write_o, bus.ex_is_load_o,
                 e.stall, e.valid, e.op, e.a, e.b, e.st, e.rd, e.rw, e.ld, e.full);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui, input logic [2:0] op,
                        input logic [4:0] rd, input logic rw, input logic ld);
    bus.id_valid_i     = v;
    bus.id_rs1_i       = rs1;
    bus.id_rs2_i       = rs2;
    bus.id_use_rs1_i   = u1;
    bus.id_use_rs2_i   = u2;
    bus.id_rs1_data_i  = d1;
    bus.id_rs2_data_i  = d2;
    bus.id_imm_i       = imm;
    bus.id_use_imm_i   = ui;
    bus.id_alu_op_i    = op;
    bus.id_rd_i        = rd;
    bus.id_reg_write_i = rw;
    bus.id_is_load_i   = ld;
  endtask

  task automatic set_fwd(input logic [4:0] erd, input logic erw, input logic eld, input logic [31:0] eres,
                         input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
    bus.exm_rd_i        = erd;
    bus.exm_reg_write_i = erw;
    bus.exm_is_load_i   = eld;
    bus.exm_result_i    = eres;
    bus.wb_rd_i         = wrd;
    bus.wb_reg_write_i  = wrw;
    bus.wb_result_i     = wres;
  endtask

  task automatic expect_out(input string tag, input logic stall, input logic valid, input logic full,
                            input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] st, input logic [4:0] rd, input logic rw, input logic ld,
                            input logic pchk, input logic [31:0] pb, input logic [31:0] pf);
    exp_t e;
    e.cyc = cyc; e.tag = tag; e.stall = stall; e.valid = valid; e.full = full;
    e.op = op; e.a = a; e.b = b; e.st = st; e.rd = rd; e.rw = rw; e.ld = ld;
    e.pchk = pchk; e.pb = pb; e.pf = pf;
    sb_q.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.mem_stall_i = 1'b0;
    bus.flush_i     = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    set_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

    step();
    expect_out("reset", 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    rst_n = 1'b1;

    step();  // ADD x3 = x1 + x2 enters decode
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 5'd3, 1'b1, 1'b0);
    expect_out("empty_ex", 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    step();  // SUB x5 = x1 - x6 enters decode
    expect_out("add_rf", 1'b0, 1'b1, 1'b1, 3'd0, 32'd5, 32'd7, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd1, 5'd6, 1'b1, 1'b1, 32'd1, 32'd3, 32'h0, 1'b0, ALU_SUB, 5'd5, 1'b1, 1'b0);

    step();  // both paths write x1: EX/MEM wins
    set_fwd(5'd1, 1'b1, 1'b0, 32'h10, 5'd1, 1'b1, 32'h20);
    expect_out("exm_priority", 1'b0, 1'b1, 1'b1, 3'd1, 32'h10, 32'd3, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 32'h0F, 32'hAAAA, 32'h100, 1'b1, ALU_OR, 5'd7, 1'b1, 1'b0);

    step();  // OR x7 = x6 | imm, x6 from WB, store data from rf
    set_fwd(5'd9, 1'b1, 1'b0, 32'h99, 5'd6, 1'b1, 32'h44);
    expect_out("wb_fwd_imm", 1'b0, 1'b1, 1'b1, 3'd3, 32'h44, 32'h100, 32'hAAAA, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 32'h200, 32'h0, 32'd8, 1'b1, ALU_ADD, 5'd4, 1'b1, 1'b1);

    step();  // LOAD x4 in EX, consumer AND x8 = x4 & x2 in decode
    set_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    set_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 32'h1111, 32'hFF, 32'h0, 1'b0, ALU_AND, 5'd8, 1'b1, 1'b0);
    expect_out("load_use_stall", 1'b1, 1'b1, 1'b1, 3'd0, 32'h200, 32'd8, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);

    step();  // bubble in EX, load in MEM
    set_fwd(5'd4, 1'b1, 1'b1, 32'h5555, 5'd0, 1'b0, 32'h0);
    expect_out("bubble", 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0);

    step();  // consumer in EX gets x4 from WB; a load in EX/MEM is not a source
    set_fwd(5'd4, 1'b1, 1'b1, 32'hBAD, 5'd4, 1'b1, 32'hCAFE);
    expect_out("load_wb_fwd", 1'b0, 1'b1, 1'b1, 3'd2, 32'hCAFE, 32'hFF, 32'hFF, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, ALU_XOR, 5'd9, 1'b1, 1'b0);

    step();  // XOR reads x0 while both paths claim to write x0
    set_fwd(5'd0, 1'b1, 1'b0, 32'hDEAD, 5'd0, 1'b1, 32'hDEAD);
    expect_out("x0_no_fwd", 1'b0, 1'b1, 1'b1, 3'd4, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 32'd3, 32'd4, 32'h0, 1'b0, ALU_SLT, 5'd10, 1'b1, 1'b0);

    step();  // SLT in EX; freeze for 3 cycles with flush held high
    set_fwd(5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    expect_out("slt", 1'b0, 1'b1, 1'b1, 3'd7, 32'd3, 32'd4, 32'd4, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd13, 5'd1, 1'b1, 1'b1, 32'h8000_0000, 32'd1, 32'h0, 1'b0, ALU_SRA, 5'd13, 1'b1, 1'b0);
    bus.mem_stall_i = 1'b1;
    bus.flush_i     = 1'b1;

    for (int i = 0; i < 2; i++) begin
      step();
      expect_out("freeze_hold", 1'b0, 1'b1, 1'b1, 3'd7, 32'd3, 32'd4, 32'd4, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    step();  // freeze released, flush still asserted
    bus.mem_stall_i = 1'b0;
    expect_out("freeze_end", 1'b0, 1'b1, 1'b1, 3'd7, 32'd3, 32'd4, 32'd4, 5'd10, 1'b1, 1'b0, 1'b1, 32'd1, 32'd3);

    step();
    bus.flush_i = 1'b0;
    expect_out("flushed", 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd3);
    set_id(1'b1, 5'd13, 5'd14, 1'b1, 1'b1, 32'h12, 32'h34, 32'h0, 1'b0, ALU_ADD, 5'd14, 1'b1, 1'b0);

    step();
    expect_out("after_flush", 1'b0, 1'b1, 1'b1, 3'd0, 32'h12, 32'h34, 32'h34, 5'd14, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    set_id(1'b1, 5'd15, 5'd16, 1'b1, 1'b1, 32'h55, 32'h66, 32'h0, 1'b0, ALU_OR, 5'd15, 1'b1, 1'b0);

    step();  // reset dropped between edges must clear outputs before the next edge
    expect_out("async_reset", 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    #1;
    rst_n = 1'b0;

    step();
    rst_n = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    expect_out("post_reset", 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      step();
    end
    if (sb_q.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
